// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write-back path.
package regbank_pkg;

   // Opcode whose results never reach the register bank.
   localparam logic [3:0] NOP_OP = 4'b1111;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 16;

   // One pending write-back: destination register and value.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of write-back requests. Besides push/pop it
// exposes every slot in age order (index 0 = oldest) with a valid bit, so
// the parent can run forwarding compares against all pending entries.
module wb_fifo
   import regbank_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  wb_req_t                push_data_i,
   input  logic                   pop_i,
   output wb_req_t                head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output wb_req_t [DEPTH-1:0]    age_entries_o,
   output logic    [DEPTH-1:0]    age_valid_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Next pointer and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset empties the queue.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Slot storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the valid bits derived from count decide what is live.
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Age-ordered view of the buffer for the forwarding compare.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx           = '0;
      age_entries_o = '0;
      age_valid_o   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx              = rd_ptr_q + PTR_W'(i);
         age_entries_o[i] = mem_q[idx];
         age_valid_o[i]   = (CNT_W'(i) < count_q);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/regbank_writeback.sv
// Write-side sequencer for the 16x32 register bank: filters NOP results,
// queues write-backs in order, drains one registered write per cycle and
// forwards the youngest pending value for two read addresses.
module regbank_writeback
   import regbank_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_opcode,
   input  logic [ADDR_W-1:0]      in_dest,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   wb_hold,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_dest,
   output logic [DATA_W-1:0]      wr_data,
   input  logic [ADDR_W-1:0]      srcadd1,
   input  logic [ADDR_W-1:0]      srcadd2,
   output logic                   hit1,
   output logic                   hit2,
   output logic [DATA_W-1:0]      fwd1,
   output logic [DATA_W-1:0]      fwd2,
   output logic [$clog2(DEPTH):0] count
);

   localparam int               CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic                push_fire;
   logic                alloc;
   logic                pop;
   wb_req_t             push_req;
   wb_req_t             head;
   wb_req_t [DEPTH-1:0] age_entries;
   logic    [DEPTH-1:0] age_valid;

   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   // Readiness depends on occupancy alone; NOPs complete the handshake
   // but never allocate a slot.
   assign in_ready  = (count != FULL_CNT);
   assign push_fire = in_valid && in_ready;
   assign alloc     = push_fire && (in_opcode != NOP_OP);
   assign pop       = (count != '0) && !wb_hold;

   assign push_req.dest = in_dest;
   assign push_req.data = in_data;

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (alloc),
      .push_data_i  (push_req),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count),
      .age_entries_o(age_entries),
      .age_valid_o  (age_valid)
   );

   // Output register next state: load the head on pop, otherwise hold.
   always_comb begin
      wr_en_d   = pop;
      wr_dest_d = wr_dest_q;
      wr_data_d = wr_data_q;
      if (pop) begin
         wr_dest_d = head.dest;
         wr_data_d = head.data;
      end
   end

   // Registered bank write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_dest_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_dest_q <= wr_dest_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_dest = wr_dest_q;
   assign wr_data = wr_data_q;

   // Forwarding compare: scan oldest-to-newest after the in-flight write so
   // the youngest match overwrites any older one.
   always_comb begin
      hit1 = 1'b0;
      fwd1 = '0;
      hit2 = 1'b0;
      fwd2 = '0;
      if (wr_en_q && (wr_dest_q == srcadd1)) begin
         hit1 = 1'b1;
         fwd1 = wr_data_q;
      end
      if (wr_en_q && (wr_dest_q == srcadd2)) begin
         hit2 = 1'b1;
         fwd2 = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && (age_entries[i].dest == srcadd1)) begin
            hit1 = 1'b1;
            fwd1 = age_entries[i].data;
         end
         if (age_valid[i] && (age_entries[i].dest == srcadd2)) begin
            hit2 = 1'b1;
            fwd2 = age_entries[i].data;
         end
      end
   end

endmodule
